mult_hilo_unit: RTL

MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

---
 rtl/mult_hilo_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mult_hilo_unit.sv
// Iterative 32x32 multiplier with HI/LO registers: mult, multu, madd, msub, mthi/mtlo.
// Latency: Start at edge E0, HI/LO written and Done pulsed after edge E33; Busy high for 33 cycles.
// Backpressure: Busy stalls the issuing pipeline; Start and moves seen while Busy are dropped, not queued.
module mult_hilo_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_MSUB  = 2'b11;

  // Operation context captured at Start; operands are not needed afterwards.
  typedef struct packed {
    logic [1:0] op;
    logic       neg;
  } op_ctx_t;

  state_t      state;
  state_t      state_nxt;
  op_ctx_t     ctx;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;

  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod;
  logic [63:0] hilo_nxt;
  logic        step_last;

  // Operand magnitudes; 0x80000000 negates to itself, which is exactly 2^31 unsigned.
  always_comb begin
    signed_op = (Op != OP_MULTU);
    a_mag     = (signed_op && A[31]) ? (~A + 32'd1) : A;
    b_mag     = (signed_op && B[31]) ? (~B + 32'd1) : B;
    step_last = (cnt == 6'd31);
  end

  // Next-state logic: IDLE -> RUN for 32 steps -> FINISH for the write-back cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (step_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any op in flight.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign Busy = (state != IDLE);

  // Signed result and full 64-bit accumulate so carries/borrows cross from LO into HI.
  always_comb begin
    prod = ctx.neg ? (~acc + 64'd1) : acc;
    case (ctx.op)
      OP_MADD: hilo_nxt = {Hi, Lo} + prod;
      OP_MSUB: hilo_nxt = {Hi, Lo} - prod;
      default: hilo_nxt = prod;
    endcase
  end

  // Shift-add datapath: one multiplier bit consumed per RUN cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctx    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            ctx.op  <= Op;
            ctx.neg <= signed_op & (A[31] ^ B[31]);
            acc     <= '0;
            cnt     <= '0;
            mcand   <= {32'd0, a_mag};
            mplier  <= b_mag;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: op write-back in FINISH; moves only in IDLE and only when no Start competes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == FINISH) begin
      {Hi, Lo} <= hilo_nxt;
    end else if (state == IDLE && !Start) begin
      if (MtHi) Hi <= WData;
      if (MtLo) Lo <= WData;
    end
  end

  // Done is a registered one-cycle pulse following the write-back edge.
  always_ff @(posedge Clk) begin
    if (Reset) Done <= 1'b0;
    else       Done <= (state == FINISH);
  end

endmodule
